// File: rtl/mem_access_ctrl.sv
// Memory-stage data-memory access controller: one bus transaction per load/store.
// Optional stall performance counter enabled by MEM_ACCESS_CTRL_PERF_EN.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] RD2M,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        bus_err,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_e;

    state_e          state_q;
    logic [TO_W-1:0] cnt_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic            we_q;
    logic            valid_q;
    logic            berr_q;

    logic            access_m;
    logic [TO_W:0]   cnt_inc;
    logic            to_hit;
    logic            unused_addr_lsb;

    assign access_m        = MemWriteM | (ResultSrcM == 2'b01);
    assign cnt_inc         = {1'b0, cnt_q} + {{TO_W{1'b0}}, 1'b1};
    assign to_hit          = (TIMEOUT != 0) && (cnt_inc == (TO_W+1)'(TIMEOUT));
    assign unused_addr_lsb = ^ALUResultM[1:0];

    // Stall is combinational so the access cycle itself freezes the pipeline.
    assign StallM    = (state_q == REQ) | ((state_q == IDLE) & access_m);
    assign ReadDataM = rdata_q;
    assign mem_valid = valid_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign bus_err   = berr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            valid_q <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            berr_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (access_m) begin
                        addr_q  <= {ALUResultM[31:2], 2'b00};
                        wdata_q <= RD2M;
                        we_q    <= MemWriteM;
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        if (!we_q) rdata_q <= mem_rdata;
                        valid_q <= 1'b0;
                        state_q <= DONE;
                    end else if (to_hit) begin
                        if (!we_q) rdata_q <= '0;
                        valid_q <= 1'b0;
                        berr_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_inc[TO_W-1:0];
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ACCESS_CTRL_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else if (StallM) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign stall_cycles = perf_q;
`else
    assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_access_ctrl;

`ifdef MEM_ACCESS_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam int TO_A = 6;
    localparam int TO_B = 3;

    logic        clk;
    logic        reset;
    logic [31:0] ALUResultM;
    logic [31:0] RD2M;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic        a_StallM, b_StallM;
    logic [31:0] a_ReadDataM, b_ReadDataM;
    logic        a_mem_valid, b_mem_valid;
    logic        a_mem_we, b_mem_we;
    logic [31:0] a_mem_addr, b_mem_addr;
    logic [31:0] a_mem_wdata, b_mem_wdata;
    logic        a_bus_err, b_bus_err;
    logic [31:0] a_stall_cycles, b_stall_cycles;

    mem_access_ctrl #(.TIMEOUT(TO_A), .TO_W(8)) dut_a (
        .clk(clk), .reset(reset),
        .ALUResultM(ALUResultM), .RD2M(RD2M),
        .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .StallM(a_StallM), .ReadDataM(a_ReadDataM),
        .mem_valid(a_mem_valid), .mem_we(a_mem_we),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .bus_err(a_bus_err), .stall_cycles(a_stall_cycles)
    );

    mem_access_ctrl #(.TIMEOUT(TO_B), .TO_W(4)) dut_b (
        .clk(clk), .reset(reset),
        .ALUResultM(ALUResultM), .RD2M(RD2M),
        .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .StallM(b_StallM), .ReadDataM(b_ReadDataM),
        .mem_valid(b_mem_valid), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .bus_err(b_bus_err), .stall_cycles(b_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    bit mchk = 1'b0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    // Transaction-level model: a bus request in flight, how long it has
    // waited, and a one-cycle cool-down after each completed access.
    typedef struct {
        bit          pend;
        int          waited;
        bit          cool;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
        logic [31:0] stalls;
    } mdl_t;

    mdl_t ma, mb;

    function automatic logic mstall(mdl_t m, logic acc);
        return m.pend | (!m.cool & acc);
    endfunction

    function automatic mdl_t mstep(mdl_t m, int to, logic r, logic acc,
                                   logic we, logic [31:0] addr,
                                   logic [31:0] wd, logic rdy,
                                   logic [31:0] rdat);
        mdl_t n;
        n = m;
        n.err = 1'b0;
        n.stalls = m.stalls + (mstall(m, acc) ? 32'd1 : 32'd0);
        if (r) begin
            n = '{default: 0};
        end else if (m.pend) begin
            if (rdy) begin
                if (!m.we) n.rd = rdat;
                n.pend = 1'b0;
                n.cool = 1'b1;
            end else if (to != 0 && m.waited + 1 == to) begin
                if (!m.we) n.rd = 32'h0;
                n.pend = 1'b0;
                n.cool = 1'b1;
                n.err = 1'b1;
            end else begin
                n.waited = m.waited + 1;
            end
        end else if (m.cool) begin
            n.cool = 1'b0;
        end else if (acc) begin
            n.pend = 1'b1;
            n.waited = 0;
            n.we = we;
            n.addr = {addr[31:2], 2'b00};
            n.wdata = wd;
        end
        return n;
    endfunction

    task automatic mcheck(input string t, input mdl_t m, input logic acc,
                          input logic st, input logic [31:0] rd,
                          input logic v, input logic we,
                          input logic [31:0] ad, input logic [31:0] wd,
                          input logic be, input logic [31:0] pc);
        check({t, "_stall"}, 32'(st), 32'(mstall(m, acc)));
        check({t, "_valid"}, 32'(v), 32'(m.pend));
        check({t, "_rdata"}, rd, m.rd);
        check({t, "_berr"}, 32'(be), 32'(m.err));
        if (m.pend) begin
            check({t, "_we"}, 32'(we), 32'(m.we));
            check({t, "_addr"}, ad, m.addr);
            check({t, "_wdata"}, wd, m.wdata);
        end
        check({t, "_perf"}, pc, PERF ? m.stalls : 32'h0);
    endtask

    task automatic tick(input logic r, input logic we, input logic [1:0] rs,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic rdy, input logic [31:0] rdat);
        logic acc;
        @(negedge clk);
        reset = r;
        MemWriteM = we;
        ResultSrcM = rs;
        ALUResultM = addr;
        RD2M = wd;
        mem_ready = rdy;
        mem_rdata = rdat;
        acc = we | (rs == 2'b01);
        #1;
        if (mchk) begin
            mcheck("mdlA", ma, acc, a_StallM, a_ReadDataM, a_mem_valid,
                   a_mem_we, a_mem_addr, a_mem_wdata, a_bus_err,
                   a_stall_cycles);
            mcheck("mdlB", mb, acc, b_StallM, b_ReadDataM, b_mem_valid,
                   b_mem_we, b_mem_addr, b_mem_wdata, b_bus_err,
                   b_stall_cycles);
        end
        ma = mstep(ma, TO_A, r, acc, we, addr, wd, rdy, rdat);
        mb = mstep(mb, TO_B, r, acc, we, addr, wd, rdy, rdat);
    endtask

    task automatic idle(input logic r);
        tick(r, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  rs;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        rdy;
        logic [31:0] rdat;
        logic        e_stall;
        logic        e_valid;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic [31:0] e_rd;
        logic        e_berr;
        logic [31:0] e_perf;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [31:0] st_pat, va_pat;
        int vcnt, ecnt, ntx;

        tbl[0]  = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'd0};
        tbl[1]  = '{1'b0, 2'b01, 32'h1006, 32'h0, 1'b0, 32'h0,
                    1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'd0};
        tbl[2]  = '{1'b0, 2'b01, 32'h1006, 32'h0, 1'b1, 32'hCAFE_F00D,
                    1'b1, 1'b1, 1'b0, 32'h1004, 32'h0, 32'h0, 1'b0, 32'd1};
        tbl[3]  = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 32'h1004, 32'h0, 32'hCAFE_F00D,
                    1'b0, 32'd2};
        tbl[4]  = tbl[3];
        tbl[5]  = '{1'b1, 2'b00, 32'h20, 32'h1234_5678, 1'b0, 32'h0,
                    1'b1, 1'b0, 1'b0, 32'h1004, 32'h0, 32'hCAFE_F00D,
                    1'b0, 32'd2};
        tbl[6]  = '{1'b1, 2'b00, 32'h20, 32'h1234_5678, 1'b0, 32'h0,
                    1'b1, 1'b1, 1'b1, 32'h20, 32'h1234_5678, 32'hCAFE_F00D,
                    1'b0, 32'd3};
        tbl[7]  = tbl[6];
        tbl[7].e_perf = 32'd4;
        tbl[8]  = tbl[6];
        tbl[8].e_perf = 32'd5;
        tbl[9]  = tbl[6];
        tbl[9].rdy = 1'b1;
        tbl[9].rdat = 32'hDEAD_BEEF;
        tbl[9].e_perf = 32'd6;
        tbl[10] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b1, 32'h20, 32'h1234_5678, 32'hCAFE_F00D,
                    1'b0, 32'd7};

        ma = '{default: 0};
        mb = '{default: 0};
        reset = 1'b1;
        MemWriteM = 1'b0;
        ResultSrcM = 2'b00;
        ALUResultM = 32'h0;
        RD2M = 32'h0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;

        idle(1'b1);
        mchk = 1'b1;
        idle(1'b1);

        // Directed load then store on the long-timeout instance
        for (int i = 0; i < 11; i++) begin
            tick(1'b0, tbl[i].we, tbl[i].rs, tbl[i].addr, tbl[i].wd,
                 tbl[i].rdy, tbl[i].rdat);
            check($sformatf("tbl%0d_stall", i), 32'(a_StallM),
                  32'(tbl[i].e_stall));
            check($sformatf("tbl%0d_valid", i), 32'(a_mem_valid),
                  32'(tbl[i].e_valid));
            check($sformatf("tbl%0d_we", i), 32'(a_mem_we), 32'(tbl[i].e_we));
            check($sformatf("tbl%0d_addr", i), a_mem_addr, tbl[i].e_addr);
            check($sformatf("tbl%0d_wdata", i), a_mem_wdata, tbl[i].e_wd);
            check($sformatf("tbl%0d_rdata", i), a_ReadDataM, tbl[i].e_rd);
            check($sformatf("tbl%0d_berr", i), 32'(a_bus_err),
                  32'(tbl[i].e_berr));
            check($sformatf("tbl%0d_perf", i), a_stall_cycles,
                  PERF ? tbl[i].e_perf : 32'h0);
        end

        // Timeout abort on the TIMEOUT=3 instance after one good load
        idle(1'b1);
        tick(1'b0, 1'b0, 2'b01, 32'h44, 32'h0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 2'b01, 32'h44, 32'h0, 1'b1, 32'hA5A5_A5A5);
        idle(1'b0);
        check("to_pre_rdata", b_ReadDataM, 32'hA5A5_A5A5);
        vcnt = 0;
        ecnt = 0;
        for (int i = 0; i < 7; i++) begin
            if (i < 4) tick(1'b0, 1'b0, 2'b01, 32'h40, 32'h0, 1'b0, 32'h0);
            else idle(1'b0);
            vcnt += int'(b_mem_valid);
            ecnt += int'(b_bus_err);
            if (i == 4) begin
                check("to_done_berr", 32'(b_bus_err), 32'd1);
                check("to_done_rdata", b_ReadDataM, 32'h0);
                check("to_done_stall", 32'(b_StallM), 32'd0);
            end
            if (i == 5) begin
                check("to_idle_berr", 32'(b_bus_err), 32'd0);
                check("to_idle_valid", 32'(b_mem_valid), 32'd0);
            end
        end
        check("to_valid_cycles", 32'(vcnt), 32'd3);
        check("to_berr_pulses", 32'(ecnt), 32'd1);

        // Ready on the same cycle the count reaches TIMEOUT is a success
        idle(1'b1);
        tick(1'b0, 1'b0, 2'b01, 32'h80, 32'h0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 2'b01, 32'h80, 32'h0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 2'b01, 32'h80, 32'h0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 2'b01, 32'h80, 32'h0, 1'b1, 32'h0BAD_CAFE);
        idle(1'b0);
        check("edge_berr", 32'(b_bus_err), 32'd0);
        check("edge_rdata", b_ReadDataM, 32'h0BAD_CAFE);

        // Back-to-back loads with the access held through DONE
        idle(1'b1);
        st_pat = 32'b00011011;
        va_pat = 32'b00010010;
        ntx = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 5) tick(1'b0, 1'b0, 2'b01, 32'h100, 32'h0, 1'b1,
                            32'h1000 + 32'(i));
            else tick(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 32'h0);
            ntx += int'(a_mem_valid & mem_ready);
            check($sformatf("b2b%0d_stall", i), 32'(a_StallM),
                  32'(st_pat[i]));
            check($sformatf("b2b%0d_valid", i), 32'(a_mem_valid),
                  32'(va_pat[i]));
            if (i == 2) check("b2b_rd1", a_ReadDataM, 32'h1001);
            if (i == 5) check("b2b_rd2", a_ReadDataM, 32'h1004);
        end
        check("b2b_txns", 32'(ntx), 32'd2);

        // Reset in the middle of a request, then a late ready
        idle(1'b1);
        tick(1'b0, 1'b0, 2'b01, 32'h88, 32'h0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 2'b01, 32'h88, 32'h0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        check("rst_pre_valid", 32'(a_mem_valid), 32'd1);
        tick(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF);
        check("rst_valid", 32'(a_mem_valid), 32'd0);
        check("rst_stall", 32'(a_StallM), 32'd0);
        check("rst_addr", a_mem_addr, 32'h0);
        check("rst_rdata", a_ReadDataM, 32'h0);
        check("rst_perf", a_stall_cycles, 32'h0);
        idle(1'b0);
        check("rst_late_valid", 32'(a_mem_valid), 32'd0);
        check("rst_late_rdata", a_ReadDataM, 32'h0);
        check("rst_late_berr", 32'(a_bus_err), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                 2'($urandom_range(0, 3)), $urandom, $urandom,
                 $urandom_range(0, 99) < 35, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
